// File: rtl/pong_pkg.sv
// Shared Pong constants: screen size, 3x5 digit glyph table and a glyph pixel lookup.
// Pure definitions, no logic state.
package pong_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int GLYPH_W = 3;
    localparam int GLYPH_H = 5;

    // Bit 2 of each row is the leftmost glyph column.
    localparam logic [2:0] FONT_3X5 [10][5] = '{
        '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
        '{3'b010, 3'b110, 3'b010, 3'b010, 3'b111},
        '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
        '{3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
        '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
        '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
        '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
        '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001},
        '{3'b111, 3'b101, 3'b111, 3'b101, 3'b111},
        '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111}
    };

    function automatic logic glyph_bit(input logic [3:0] digit,
                                       input logic [2:0] row,
                                       input logic [1:0] col);
        logic [2:0] w_bits;
        glyph_bit = 1'b0;
        if (digit <= 4'd9 && row <= 3'd4 && col <= 2'd2) begin
            w_bits    = FONT_3X5[digit][row];
            glyph_bit = w_bits[2'd2 - col];
        end
    endfunction

endpackage

// File: rtl/score_digit_box.sv
// Hit test of one scaled digit box: in_box flag plus glyph row/col of the pixel.
// Purely combinational.
module score_digit_box
    import pong_pkg::*;
#(
    parameter int CORDW       = 10,
    parameter int DIGIT_SHIFT = 2
) (
    input  logic [CORDW-1:0] i_box_x,
    input  logic [CORDW-1:0] i_box_y,
    input  logic [CORDW-1:0] i_sx,
    input  logic [CORDW-1:0] i_sy,
    output logic             o_in_box,
    output logic [2:0]       o_row,
    output logic [1:0]       o_col
);

    localparam logic [CORDW-1:0] BOX_W = CORDW'(GLYPH_W << DIGIT_SHIFT);
    localparam logic [CORDW-1:0] BOX_H = CORDW'(GLYPH_H << DIGIT_SHIFT);

    logic             w_in_x;
    logic             w_in_y;
    logic [CORDW-1:0] w_dx;
    logic [CORDW-1:0] w_dy;
    logic [CORDW-1:0] w_col_full;
    logic [CORDW-1:0] w_row_full;
    logic             w_unused_hi;

    assign w_in_x   = (i_sx >= i_box_x) && (i_sx < i_box_x + BOX_W);
    assign w_in_y   = (i_sy >= i_box_y) && (i_sy < i_box_y + BOX_H);
    assign o_in_box = w_in_x && w_in_y;

    // Offsets are zeroed outside the box so row/col never wrap to garbage.
    assign w_dx       = o_in_box ? (i_sx - i_box_x) : '0;
    assign w_dy       = o_in_box ? (i_sy - i_box_y) : '0;
    assign w_col_full = w_dx >> DIGIT_SHIFT;
    assign w_row_full = w_dy >> DIGIT_SHIFT;
    assign o_col      = w_col_full[1:0];
    assign o_row      = w_row_full[2:0];

    assign w_unused_hi = ^{w_col_full[CORDW-1:2], w_row_full[CORDW-1:3]};

endmodule

// File: rtl/pong_score.sv
// Pong score keeper (1-cycle update after a collision edge) and two-digit score overlay.
// s_draw lags sx/sy/de by 2 cycles; no backpressure, one result per pixel clock.
module pong_score
    import pong_pkg::*;
#(
    parameter int CORDW       = 10,
    parameter int WIN_SCORE   = 9,
    parameter int DIGIT_SHIFT = 2,
    parameter int P1_X        = 256,
    parameter int P2_X        = 372,
    parameter int SCORE_Y     = 16
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             lft_col,
    input  logic             rgt_col,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    output logic [3:0]       score_p1,
    output logic [3:0]       score_p2,
    output logic             game_over,
    output logic             winner,
    output logic             s_draw
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    logic       r_lft_q;
    logic       r_rgt_q;
    logic [3:0] r_score_p1;
    logic [3:0] r_score_p2;
    logic       r_game_over;
    logic       r_winner;

    logic       w_point_p1;
    logic       w_point_p2;
    logic [3:0] w_p1_nxt;
    logic [3:0] w_p2_nxt;
    logic       w_go_nxt;
    logic       w_win_nxt;

    assign w_point_p2 = lft_col & ~r_lft_q;
    assign w_point_p1 = rgt_col & ~r_rgt_q;

    always_comb begin
        w_p1_nxt  = r_score_p1;
        w_p2_nxt  = r_score_p2;
        w_go_nxt  = r_game_over;
        w_win_nxt = r_winner;
        if (clear) begin
            w_p1_nxt  = '0;
            w_p2_nxt  = '0;
            w_go_nxt  = 1'b0;
            w_win_nxt = 1'b0;
        end else if (!r_game_over) begin
            if (w_point_p1) w_p1_nxt = r_score_p1 + 4'd1;
            if (w_point_p2) w_p2_nxt = r_score_p2 + 4'd1;
            w_go_nxt  = (w_p1_nxt == WIN) || (w_p2_nxt == WIN);
            // A simultaneous finish is credited to player 1.
            w_win_nxt = (w_p2_nxt == WIN) && (w_p1_nxt != WIN);
        end
    end

    // History starts high so a collision already asserted at reset release is not a point.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_q     <= 1'b1;
            r_rgt_q     <= 1'b1;
            r_score_p1  <= '0;
            r_score_p2  <= '0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
        end else begin
            r_lft_q     <= lft_col;
            r_rgt_q     <= rgt_col;
            r_score_p1  <= w_p1_nxt;
            r_score_p2  <= w_p2_nxt;
            r_game_over <= w_go_nxt;
            r_winner    <= w_win_nxt;
        end
    end

    assign score_p1  = r_score_p1;
    assign score_p2  = r_score_p2;
    assign game_over = r_game_over;
    assign winner    = r_winner;

    logic       w_in_box1;
    logic       w_in_box2;
    logic [2:0] w_row1;
    logic [2:0] w_row2;
    logic [1:0] w_col1;
    logic [1:0] w_col2;

    score_digit_box #(.CORDW(CORDW), .DIGIT_SHIFT(DIGIT_SHIFT)) u_box_p1 (
        .i_box_x  (CORDW'(P1_X)),
        .i_box_y  (CORDW'(SCORE_Y)),
        .i_sx     (sx),
        .i_sy     (sy),
        .o_in_box (w_in_box1),
        .o_row    (w_row1),
        .o_col    (w_col1)
    );

    score_digit_box #(.CORDW(CORDW), .DIGIT_SHIFT(DIGIT_SHIFT)) u_box_p2 (
        .i_box_x  (CORDW'(P2_X)),
        .i_box_y  (CORDW'(SCORE_Y)),
        .i_sx     (sx),
        .i_sy     (sy),
        .o_in_box (w_in_box2),
        .o_row    (w_row2),
        .o_col    (w_col2)
    );

    logic       r_in_any;
    logic [2:0] r_row;
    logic [1:0] r_col;
    logic [3:0] r_digit;
    logic       r_de_d1;
    logic       r_s_draw;

    // Box 1 takes precedence should the boxes ever be configured to overlap.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_in_any <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            r_digit  <= '0;
            r_de_d1  <= 1'b0;
            r_s_draw <= 1'b0;
        end else begin
            r_in_any <= w_in_box1 | w_in_box2;
            r_row    <= w_in_box1 ? w_row1 : w_row2;
            r_col    <= w_in_box1 ? w_col1 : w_col2;
            r_digit  <= w_in_box1 ? r_score_p1 : r_score_p2;
            r_de_d1  <= de;
            r_s_draw <= r_de_d1 & r_in_any & glyph_bit(r_digit, r_row, r_col);
        end
    end

    assign s_draw = r_s_draw;

endmodule
